vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA timing generator that runs entirely on board_clk and derives the pixel rate with a clock-enable, replacing the divided-clock sync generator.
Produces the h/v sync, video_on and pixel coordinates consumed by the graphics, button and score units.
Generalised over resolution, porch widths, sync polarity and pixel divide ratio.
Adds line_start/frame_start strobes for game-logic updates.

Parameters:
CLK_DIV, 4, board_clk cycles per pixel (>=1)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, horizontal sync width (>=1)
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vertical sync width (>=1)
V_BP, 33, vertical back porch
HS_POL, 0, h_sync active level (0 = active-low)
VS_POL, 0, v_sync active level
CW, 10, coordinate width; must hold max(H_TOTAL,V_TOTAL)-1

Ports:
board_clk  in  1  system clock; sole clock of the block
Reset  in  1  asynchronous, active-high
en  in  1  run enable; low freezes divider and counters
pix_tick  out  1  one-cycle pixel enable; counters advance on the edge ending this cycle
vga_h_sync  out  1  horizontal sync
vga_v_sync  out  1  vertical sync
video_on  out  1  high inside the active area
pix_x  out  CW  horizontal count, including blanking
pix_y  out  CW  vertical count, including blanking
line_start  out  1  one-cycle strobe when pix_x becomes 0
frame_start  out  1  one-cycle strobe when pix_x and pix_y become 0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Reset is asynchronous, active-high; the clock is board_clk.
- Reset values:
  - div_cnt=0, pix_tick=0
  - pix_x=H_TOTAL-1, pix_y=V_TOTAL-1
  - video_on=0, line_start=0, frame_start=0
  - vga_h_sync=~HS_POL, vga_v_sync=~VS_POL
  - With these values, the first pixel step after reset lands on (0,0).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while en=1.
  - pix_tick is combinational: en && div_cnt==CLK_DIV-1.
  - CLK_DIV=1 gives pix_tick=en.
- Counter step on a board_clk edge with pix_tick=1:
  - pix_x increments; pix_x=H_TOTAL-1 wraps to 0 and pix_y increments.
  - pix_y=V_TOTAL-1 wraps to 0 on that same wrap.
- All of video_on, vga_h_sync, vga_v_sync, line_start and frame_start are registered and decoded from next-state counts. They therefore change on the same edge as pix_x/pix_y, with zero skew to the coordinates.
- video_on = (pix_x<H_ACTIVE) && (pix_y<V_ACTIVE).
- h_sync is active for pix_x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; v_sync likewise on pix_y.
- line_start and frame_start are high for exactly one board_clk cycle after the step that produces pix_x=0 (resp. both coordinates 0); low otherwise, including while en=0.
- en=0: div_cnt, counters and all outputs hold; pix_tick=0. On en=1 the divider resumes from its held count; there is no restart.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronously). Release is synchronous to board_clk.
- No combinational path from en to sync/coordinate outputs.

Optional Feature:
VGA_FRAME_CNT_EN:
- Defined: adds output frame_cnt[15:0], reset 0. It increments on the same edge that raises frame_start and wraps 65535->0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds the 640x480@60 defaults and H_TOTAL/V_TOTAL helper constants, shared with the graphics unit.
- Sub-module clk_en_div holds the parametrised divider producing pix_tick, reused by the score-display scanner.

Test Plan:
1. Reset release, CLK_DIV=4, en=1 -> first pix_tick in the 4th cycle; next edge pix_x=0, pix_y=0, video_on=1, line_start=frame_start=1 for one cycle.
2. Sweep line 0 -> video_on falls at pix_x=640; vga_h_sync low for pix_x 656..751 and high at 752; pix_tick period 4 cycles.
3. Line/frame wrap -> pix_x 799->0 with pix_y+1 and line_start; pix_y 524->0 with frame_start; vga_v_sync low exactly for pix_y 490..491.
4. en low 50 cycles at pix_x=100, div_cnt=2 -> no output change, pix_tick=0; after en=1, pix_x=101 after 2 cycles.
5. Reset pulse at pix_y=300 -> outputs at reset values within the same cycle; after release, sequence restarts as in scenario 1.
6. Free run, VGA_FRAME_CNT_EN defined -> frame_start spacing 1,680,000 cycles; frame_cnt 0->1->2; HS_POL=1 build gives inverted h_sync.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing defaults and frame total helpers.
// Shared by the timing generator and the graphics unit.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CW       = 10;

  function automatic int span_total(
    input int act,
    input int fp,
    input int syn,
    input int bp
  );
    return act + fp + syn + bp;
  endfunction

  localparam int DEF_H_TOTAL = span_total(
    DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = span_total(
    DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_gen_clk_en_div.sv
// clk_en_div: free-running clock-enable divider, one tick per DIV cycles.
// Ports: board_clk, Reset (async high), en (run), tick (en && last count).
module clk_en_div #(
  parameter int DIV = 4
) (
  input  logic board_clk,
  input  logic Reset,
  input  logic en,
  output logic tick
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt;

  // Holds its count while en is low so a resume does not restart the period.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      div_cnt <= '0;
    end else if (en) begin
      if (div_cnt == LAST) div_cnt <= '0;
      else                 div_cnt <= div_cnt + DW'(1);
    end
  end

  assign tick = en && (div_cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: board_clk VGA timing with pixel clock-enable.
// Ports: board_clk, Reset, en -> pix_tick, vga_h_sync, vga_v_sync,
//   video_on, pix_x, pix_y, line_start, frame_start
//   (+ frame_cnt[15:0] when VGA_FRAME_CNT_EN is defined).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = DEF_CLK_DIV,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = DEF_CW
) (
  input  logic          board_clk,
  input  logic          Reset,
  input  logic          en,
  output logic          pix_tick,
  output logic          vga_h_sync,
  output logic          vga_v_sync,
  output logic          video_on,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] X_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_VIS  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] Y_VIS  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_LO  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_HI  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_LO  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_HI  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] x_nx;
  logic [CW-1:0] y_nx;
  logic          ls_nx;
  logic          fs_nx;

  clk_en_div #(
    .DIV (CLK_DIV)
  ) u_div (
    .board_clk (board_clk),
    .Reset     (Reset),
    .en        (en),
    .tick      (pix_tick)
  );

  always_comb begin
    x_nx = pix_x;
    y_nx = pix_y;
    if (pix_tick) begin
      if (pix_x == X_LAST) begin
        x_nx = '0;
        if (pix_y == Y_LAST) y_nx = '0;
        else                 y_nx = pix_y + CW'(1);
      end else begin
        x_nx = pix_x + CW'(1);
      end
    end
  end

  assign ls_nx = pix_tick && (x_nx == '0);
  assign fs_nx = ls_nx && (y_nx == '0);

  // Flags decode the next counts so they change on the same edge as
  // the coordinates they describe.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      pix_x       <= X_LAST;
      pix_y       <= Y_LAST;
      video_on    <= 1'b0;
      vga_h_sync  <= ~HS_POL;
      vga_v_sync  <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_x       <= x_nx;
      pix_y       <= y_nx;
      video_on    <= (x_nx < X_VIS) && (y_nx < Y_VIS);
      vga_h_sync  <= ((x_nx >= HS_LO) && (x_nx <= HS_HI)) ?
                     HS_POL : ~HS_POL;
      vga_v_sync  <= ((y_nx >= VS_LO) && (y_nx <= VS_HI)) ?
                     VS_POL : ~VS_POL;
      line_start  <= ls_nx;
      frame_start <= fs_nx;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset)      frame_cnt <= '0;
    else if (fs_nx) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized run-enable stimulus against a
// linear-pixel-index reference model on a reduced timing geometry.
module tb_vga_timing_gen;

  localparam int   D   = 3;
  localparam int   HA  = 20;
  localparam int   HFP = 3;
  localparam int   HSW = 4;
  localparam int   HBP = 5;
  localparam int   VA  = 10;
  localparam int   VFP = 2;
  localparam int   VSW = 2;
  localparam int   VBP = 3;
  localparam logic HP  = 1'b0;
  localparam logic VP  = 1'b1;
  localparam int   CW  = 6;
  localparam int   HT  = HA + HFP + HSW + HBP;
  localparam int   VT  = VA + VFP + VSW + VBP;
  localparam int   FT  = HT * VT;

  logic          board_clk = 1'b0;
  logic          Reset;
  logic          en;
  logic          pix_tick;
  logic          vga_h_sync;
  logic          vga_v_sync;
  logic          video_on;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  vga_timing_gen #(
    .CLK_DIV (D),  .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW),
    .H_BP (HBP),   .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW),
    .V_BP (VBP),   .HS_POL (HP),   .VS_POL (VP), .CW (CW)
  ) dut (
    .board_clk   (board_clk),
    .Reset       (Reset),
    .en          (en),
    .pix_tick    (pix_tick),
    .vga_h_sync  (vga_h_sync),
    .vga_v_sync  (vga_v_sync),
    .video_on    (video_on),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 board_clk = ~board_clk;

  int tests = 0;
  int fails = 0;

  // Model: p is the linear pixel index y*HT+x; ec counts enabled cycles.
  int p, ec, fc, cyc, last_fs;
  bit ls, fs, free_run;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    p = FT - 1; ec = 0; fc = 0; ls = 0; fs = 0; last_fs = -1;
  endtask

  task automatic check_all();
    int x, y;
    x = p % HT;
    y = p / HT;
    chk("pix_x", 32'(pix_x), x);
    chk("pix_y", 32'(pix_y), y);
    chk("video_on", 32'(video_on), 32'(x < HA && y < VA));
    chk("h_sync", 32'(vga_h_sync),
        32'((x >= HA + HFP && x < HA + HFP + HSW) ? HP : !HP));
    chk("v_sync", 32'(vga_v_sync),
        32'((y >= VA + VFP && y < VA + VFP + VSW) ? VP : !VP));
    chk("line_start", 32'(line_start), 32'(ls));
    chk("frame_start", 32'(frame_start), 32'(fs));
`ifdef VGA_FRAME_CNT_EN
    chk("frame_cnt", 32'(frame_cnt), fc % 65536);
`endif
    if (free_run && frame_start === 1'b1) begin
      if (last_fs >= 0) chk("fs_gap", cyc - last_fs, FT * D);
      last_fs = cyc;
    end
  endtask

  task automatic step();
    bit t;
    @(negedge board_clk);
    t = !Reset && en && (ec % D == D - 1);
    chk("pix_tick", 32'(pix_tick), 32'(t));
    @(posedge board_clk);
    cyc++;
    if (!Reset) begin
      if (en) ec++;
      ls = 0;
      fs = 0;
      if (t) begin
        p  = (p + 1) % FT;
        ls = (p % HT == 0);
        fs = (p == 0);
        if (fs) fc++;
      end
    end
    #1 check_all();
  endtask

  initial begin
    int n;
    cyc = 0;
    free_run = 0;
    Reset = 1'b1;
    en = 1'b0;
    model_reset();
    #3 check_all();
    repeat (3) step();
    Reset = 1'b0;
    en = 1'b1;

    // First pixel step after release lands on (0,0).
    repeat (D) step();
    chk("first_x", 32'(pix_x), 0);
    chk("first_fs", 32'(frame_start), 1);

    // Two free-running frames; frame_start spacing is checked.
    free_run = 1;
    repeat (2 * FT * D + 4) step();
    free_run = 0;

    // Randomized run-enable, including long en-low holds.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 200) == 0) begin
        en = 1'b0;
        repeat (50) step();
      end else begin
        step();
      end
    end

    // Mid-frame asynchronous reset.
    en = 1'b1;
    n = 0;
    while (p / HT != 8 && n < 4 * FT * D) begin
      step();
      n++;
    end
    chk("reach_row8", 32'(p / HT), 8);
    @(negedge board_clk);
    #2 Reset = 1'b1;
    model_reset();
    #1 check_all();
    repeat (2) step();
    Reset = 1'b0;
    repeat (D) step();
    chk("restart_fs", 32'(frame_start), 1);
    free_run = 1;
    repeat (FT * D + 4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
